// File: rtl/mul_sequencer_pkg.sv
// Shared types for the RV32M multiply sequencer: core op encoding, funct3 codes, FSM states.
package mul_sequencer_pkg;

  typedef enum logic [1:0] {
    mulop_mul    = 2'd0,
    mulop_mulh   = 2'd1,
    mulop_mulhsu = 2'd2,
    mulop_mulhu  = 2'd3
  } rv32_mulop;

  localparam logic [2:0] MUL_F3_MUL    = 3'b000;
  localparam logic [2:0] MUL_F3_MULH   = 3'b001;
  localparam logic [2:0] MUL_F3_MULHSU = 3'b010;
  localparam logic [2:0] MUL_F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mul_seq_state_t;

endpackage

// File: rtl/mul_sequencer.sv
// Issue/retire sequencer between execute and the multi-cycle Booth multiply core.
// MUL_FUSE_EN: reuse the core's held low product for a repeated MUL with identical operands.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [2:0]   i_funct3,
  input  logic [N-1:0] i_rs1,
  input  logic [N-1:0] i_rs2,
  input  logic [4:0]   i_rd,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [4:0]   o_rd,
  output logic [N-1:0] o_result,
  output logic         o_illegal,
  output logic         o_core_en,
  output rv32_mulop    o_core_mulop,
  output logic [N-1:0] o_core_a,
  output logic [N-1:0] o_core_b,
  output logic [N-1:0] o_core_c,
  input  logic [N-1:0] i_core_data,
  input  logic         i_core_stall
);

  mul_seq_state_t state;
  logic [N-1:0]   rs1_q, rs2_q, result_q;
  logic [4:0]     rd_q;
  rv32_mulop      mulop_q;
  logic           valid_q, en_q, illegal_q, fuse_q;
  logic           accept, f3_illegal, fuse_hit;
  rv32_mulop      f3_op;

  always_comb begin
    f3_illegal = i_funct3[2];
    f3_op      = mulop_mul;
    case (i_funct3)
      MUL_F3_MULH:   f3_op = mulop_mulh;
      MUL_F3_MULHSU: f3_op = mulop_mulhsu;
      MUL_F3_MULHU:  f3_op = mulop_mulhu;
      default:       f3_op = mulop_mul;
    endcase
  end

  // A flush in the same cycle as a request wins: nothing is accepted.
  assign o_ready = (state == IDLE) && !i_core_stall;
  assign accept  = i_valid && o_ready && !i_flush;

`ifdef MUL_FUSE_EN
  logic [N-1:0] tag_rs1, tag_rs2;
  logic         tag_vld;
  assign fuse_hit = tag_vld && !f3_illegal && (f3_op == mulop_mul) &&
                    (i_rs1 == tag_rs1) && (i_rs2 == tag_rs2);
`else
  assign fuse_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      mulop_q   <= mulop_mul;
      result_q  <= '0;
      valid_q   <= 1'b0;
      en_q      <= 1'b0;
      illegal_q <= 1'b0;
      fuse_q    <= 1'b0;
`ifdef MUL_FUSE_EN
      tag_vld   <= 1'b0;
      tag_rs1   <= '0;
      tag_rs2   <= '0;
`endif
    end else if (i_flush) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      en_q      <= 1'b0;
      illegal_q <= 1'b0;
      fuse_q    <= 1'b0;
`ifdef MUL_FUSE_EN
      tag_vld   <= 1'b0;
`endif
    end else begin
      en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rs1_q <= i_rs1;
            rs2_q <= i_rs2;
            rd_q  <= i_rd;
            if (f3_illegal) begin
              result_q  <= '0;
              illegal_q <= 1'b1;
              valid_q   <= 1'b1;
              state     <= DONE;
            end else if (fuse_hit) begin
              mulop_q   <= mulop_mul;
              illegal_q <= 1'b0;
              fuse_q    <= 1'b1;
              valid_q   <= 1'b1;
              state     <= DONE;
            end else begin
              mulop_q   <= f3_op;
              illegal_q <= 1'b0;
              en_q      <= 1'b1;
              state     <= ISSUE;
`ifdef MUL_FUSE_EN
              tag_vld   <= 1'b0;
`endif
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (!i_core_stall) begin
            result_q <= i_core_data;
            valid_q  <= 1'b1;
            state    <= DONE;
`ifdef MUL_FUSE_EN
            tag_vld  <= 1'b1;
            tag_rs1  <= rs1_q;
            tag_rs2  <= rs2_q;
`endif
          end
        end
        DONE: begin
          // Fused result comes straight from the core in its first DONE cycle, then is held locally.
          if (fuse_q) begin
            result_q <= i_core_data;
            fuse_q   <= 1'b0;
          end
          if (i_ready) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_valid      = valid_q;
  assign o_rd         = rd_q;
  assign o_result     = fuse_q ? i_core_data : result_q;
  assign o_illegal    = illegal_q;
  assign o_core_en    = en_q;
  assign o_core_mulop = mulop_q;
  assign o_core_a     = rs1_q;
  assign o_core_b     = rs2_q;
  assign o_core_c     = '0;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural stand-in for the multiply core.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_rs1 = '0, i_rs2 = '0;
  logic [4:0]  i_rd = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [4:0]  o_rd;
  logic [31:0] o_result;
  logic        o_illegal;
  logic        o_core_en;
  rv32_mulop   o_core_mulop;
  logic [31:0] o_core_a, o_core_b, o_core_c;
  logic [31:0] core_data;
  logic        core_stall = 1'b0;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int stall_cfg = 0;
  int scnt = 0;
  logic [31:0] ca = '0, cb = '0;

  always #5 clk = ~clk;

  mul_sequencer #(.N(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_rd(o_rd),
    .o_result(o_result), .o_illegal(o_illegal), .o_core_en(o_core_en),
    .o_core_mulop(o_core_mulop), .o_core_a(o_core_a), .o_core_b(o_core_b),
    .o_core_c(o_core_c), .i_core_data(core_data), .i_core_stall(core_stall)
  );

  // Core stand-in: latches operands on en, stalls for stall_cfg cycles, output muxed by mulop.
  always @(posedge clk) begin
    if (o_core_en) en_cnt++;
    if (rst) begin
      core_stall <= 1'b0;
      scnt       <= 0;
    end else if (o_core_en) begin
      ca         <= o_core_a;
      cb         <= o_core_b;
      scnt       <= stall_cfg;
      core_stall <= (stall_cfg > 0);
    end else if (scnt > 0) begin
      scnt       <= scnt - 1;
      core_stall <= (scnt > 1);
    end
  end

  always_comb begin
    logic [63:0] p;
    p = '0;
    case (o_core_mulop)
      mulop_mulh:   p = {{32{ca[31]}}, ca} * {{32{cb[31]}}, cb};
      mulop_mulhsu: p = {{32{ca[31]}}, ca} * {32'd0, cb};
      mulop_mulhu:  p = {32'd0, ca} * {32'd0, cb};
      default:      p = {32'd0, ca} * {32'd0, cb};
    endcase
    core_data = (o_core_mulop == mulop_mul) ? p[31:0] : p[63:32];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    int n = 0;
    @(negedge clk);
    i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Returns cycles from accept to o_valid (1 = cycle after accept) and cycles with unexpected mulop.
  task automatic wait_valid(input rv32_mulop exp_op, output int lat, output int op_bad);
    lat = 1;
    op_bad = 0;
    while (!o_valid && lat < 100) begin
      if (o_core_mulop !== exp_op) op_bad++;
      @(negedge clk);
      lat++;
    end
    if (o_core_mulop !== exp_op) op_bad++;
  endtask

  task automatic retire();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_core_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", o_core_en); end
    checks++; if (o_illegal !== 1'b0 || o_rd !== 5'd0 || o_result !== 32'd0)
      begin errors++; $display("FAIL reset_outs got ill=%b rd=%0d res=%h want 0", o_illegal, o_rd, o_result); end
    checks++; if (o_core_mulop !== mulop_mul || o_core_a !== 32'd0 || o_core_b !== 32'd0 || o_core_c !== 32'd0)
      begin errors++; $display("FAIL reset_core got op=%0d a=%h b=%h c=%h want 0", o_core_mulop, o_core_a, o_core_b, o_core_c); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
  endtask

  task automatic test_mul();
    int lat, bad, e0;
    stall_cfg = 8;
    e0 = en_cnt;
    send(MUL_F3_MUL, 32'd7, 32'd6, 5'd5);
    wait_valid(mulop_mul, lat, bad);
    checks++; if (lat !== 11) begin errors++; $display("FAIL mul_latency got %0d want 11", lat); end
    checks++; if (o_result !== 32'd42) begin errors++; $display("FAIL mul_result got %0d want 42", o_result); end
    checks++; if (o_rd !== 5'd5 || o_illegal !== 1'b0)
      begin errors++; $display("FAIL mul_tag got rd=%0d ill=%b want 5 0", o_rd, o_illegal); end
    checks++; if (en_cnt - e0 !== 1) begin errors++; $display("FAIL mul_en_pulses got %0d want 1", en_cnt - e0); end
    checks++; if (bad !== 0 || o_core_a !== 32'd7 || o_core_b !== 32'd6)
      begin errors++; $display("FAIL mul_core_hold got badops=%0d a=%0d b=%0d want 0 7 6", bad, o_core_a, o_core_b); end
    retire();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mul_retire got valid=%b want 0", o_valid); end
  endtask

  task automatic test_high_ops();
    logic [2:0]  f3s [3] = '{MUL_F3_MULH, MUL_F3_MULHU, MUL_F3_MULHSU};
    rv32_mulop   ops [3] = '{mulop_mulh, mulop_mulhu, mulop_mulhsu};
    logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002};
    logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int lat, bad;
    stall_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      send(f3s[i], as[i], bs[i], 5'(i + 10));
      wait_valid(ops[i], lat, bad);
      checks++; if (o_result !== exp[i] || lat !== 3 || bad !== 0)
        begin errors++; $display("FAIL high_op%0d got res=%h lat=%0d badops=%0d want %h 3 0", i, o_result, lat, bad, exp[i]); end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat, bad, e0, vbad;
    stall_cfg = 1;
    send(MUL_F3_MUL, 32'd3, 32'd4, 5'd7);
    wait_valid(mulop_mul, lat, bad);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    e0 = en_cnt;
    vbad = 0;
    i_valid = 1'b1; i_funct3 = MUL_F3_MUL; i_rs1 = 32'd1; i_rs2 = 32'd1; i_rd = 5'd1;
    for (int c = 0; c < 5; c++) begin
      if (o_valid !== 1'b1 || o_result !== 32'd12 || o_rd !== 5'd7 || o_ready !== 1'b0) vbad++;
      @(negedge clk);
    end
    checks++; if (vbad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", vbad); end
    checks++; if (en_cnt !== e0) begin errors++; $display("FAIL bp_no_en got %0d pulses want 0", en_cnt - e0); end
    retire();
    i_valid = 1'b0;
    checks++; if (o_core_a !== 32'd3 || o_valid !== 1'b0)
      begin errors++; $display("FAIL bp_no_same_cycle_accept got a=%0d valid=%b want 3 0", o_core_a, o_valid); end
  endtask

  task automatic test_flush();
    int lat, bad, e0, vbad, rbad;
    stall_cfg = 10;
    send(MUL_F3_MUL, 32'd9, 32'd9, 5'd3);
    repeat (2) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low got %b want 0", o_ready); end
    vbad = 0; rbad = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_valid !== 1'b0) vbad++;
      if (core_stall && o_ready !== 1'b0) rbad++;
      @(negedge clk);
    end
    checks++; if (vbad !== 0 || rbad !== 0)
      begin errors++; $display("FAIL flush_quiet got valid_cycles=%0d ready_cycles=%0d want 0 0", vbad, rbad); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_back got %b want 1", o_ready); end
    // Request coinciding with a flush must be dropped.
    e0 = en_cnt;
    i_valid = 1'b1; i_flush = 1'b1; i_funct3 = MUL_F3_MUL; i_rs1 = 32'd77; i_rs2 = 32'd2; i_rd = 5'd2;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (en_cnt !== e0 || o_valid !== 1'b0 || o_core_a !== 32'd9)
      begin errors++; $display("FAIL flush_vs_accept got en=%0d valid=%b a=%0d want 0 0 9", en_cnt - e0, o_valid, o_core_a); end
    stall_cfg = 3;
    e0 = en_cnt;
    send(MUL_F3_MULHU, 32'd5, 32'd7, 5'd4);
    wait_valid(mulop_mulhu, lat, bad);
    checks++; if (o_result !== 32'd0 || lat !== 6 || en_cnt - e0 !== 1 || o_rd !== 5'd4)
      begin errors++; $display("FAIL flush_next got res=%h lat=%0d en=%0d rd=%0d want 0 6 1 4", o_result, lat, en_cnt - e0, o_rd); end
    retire();
    stall_cfg = 2;
    send(MUL_F3_MUL, 32'd5, 32'd7, 5'd4);
    wait_valid(mulop_mul, lat, bad);
    checks++; if (o_result !== 32'd35 || lat !== 5)
      begin errors++; $display("FAIL flush_next_mul got res=%0d lat=%0d want 35 5", o_result, lat); end
    retire();
  endtask

  task automatic test_illegal();
    int lat, bad, e0;
    e0 = en_cnt;
    send(3'b100, 32'd11, 32'd12, 5'd9);
    wait_valid(mulop_mul, lat, bad);
    checks++; if (lat !== 1 || en_cnt !== e0)
      begin errors++; $display("FAIL illegal_path got lat=%0d en=%0d want 1 0", lat, en_cnt - e0); end
    checks++; if (o_illegal !== 1'b1 || o_result !== 32'd0 || o_rd !== 5'd9)
      begin errors++; $display("FAIL illegal_outs got ill=%b res=%h rd=%0d want 1 0 9", o_illegal, o_result, o_rd); end
    retire();
    checks++; if (o_illegal !== 1'b0 || o_valid !== 1'b0)
      begin errors++; $display("FAIL illegal_clear got ill=%b valid=%b want 0 0", o_illegal, o_valid); end
  endtask

  task automatic test_fuse();
    int lat, bad, e0;
    stall_cfg = 2;
    send(MUL_F3_MULH, 32'd3, 32'd5, 5'd6);
    wait_valid(mulop_mulh, lat, bad);
    checks++; if (o_result !== 32'd0 || lat !== 5)
      begin errors++; $display("FAIL fuse_mulh got res=%h lat=%0d want 0 5", o_result, lat); end
    retire();
    e0 = en_cnt;
    send(MUL_F3_MUL, 32'd3, 32'd5, 5'd8);
    wait_valid(mulop_mul, lat, bad);
`ifdef MUL_FUSE_EN
    checks++; if (o_result !== 32'd15 || lat !== 1 || en_cnt !== e0)
      begin errors++; $display("FAIL fuse_hit got res=%0d lat=%0d en=%0d want 15 1 0", o_result, lat, en_cnt - e0); end
    @(negedge clk);
    checks++; if (o_result !== 32'd15 || o_valid !== 1'b1 || o_rd !== 5'd8)
      begin errors++; $display("FAIL fuse_hold got res=%0d valid=%b rd=%0d want 15 1 8", o_result, o_valid, o_rd); end
`else
    checks++; if (o_result !== 32'd15 || lat !== 5 || en_cnt - e0 !== 1)
      begin errors++; $display("FAIL nofuse_repeat got res=%0d lat=%0d en=%0d want 15 5 1", o_result, lat, en_cnt - e0); end
`endif
    retire();
    e0 = en_cnt;
    send(MUL_F3_MUL, 32'd3, 32'd6, 5'd8);
    wait_valid(mulop_mul, lat, bad);
    checks++; if (o_result !== 32'd18 || lat !== 5 || en_cnt - e0 !== 1)
      begin errors++; $display("FAIL fuse_miss got res=%0d lat=%0d en=%0d want 18 5 1", o_result, lat, en_cnt - e0); end
    retire();
  endtask

  task automatic test_reset_mid();
    stall_cfg = 6;
    send(MUL_F3_MULHU, 32'd2, 32'd2, 5'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0 || o_core_en !== 1'b0 || o_core_a !== 32'd0 || o_rd !== 5'd0 || o_core_mulop !== mulop_mul)
      begin errors++; $display("FAIL reset_mid got valid=%b en=%b a=%h rd=%0d op=%0d want 0", o_valid, o_core_en, o_core_a, o_rd, o_core_mulop); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %b want 1", o_ready); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_high_ops();
    test_backpressure();
    test_flush();
    test_illegal();
    test_fuse();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
